// File: rtl/junction_pkg.sv
// Shared types and default timing for the major/minor junction sequencer.
package junction_pkg;

  typedef enum logic [2:0] {
    MAJ_GRN  = 3'd0,
    MAJ_AMB  = 3'd1,
    RED_A    = 3'd2,
    MIN_GRN  = 3'd3,
    MIN_AMB  = 3'd4,
    PED_WALK = 3'd5,
    RED_B    = 3'd6
  } phase_t;

  typedef enum logic {
    CAR = 1'b0,
    PED = 1'b1
  } req_t;

  localparam int DEF_CNT_W     = 4;
  localparam int DEF_T_MAJ_MIN = 8;
  localparam int DEF_T_AMBER   = 3;
  localparam int DEF_T_ALLRED  = 1;
  localparam int DEF_T_MIN_GRN = 5;
  localparam int DEF_T_WALK    = 6;

endpackage

// File: rtl/interval_timer.sv
// Tick-enabled down-counter; a load beats a coincident tick, expired while the count is zero.
module interval_timer #(
  parameter int CNT_W   = 4,
  parameter int RST_VAL = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)
      count <= CNT_W'(RST_VAL);
    else if (load)
      count <= load_val;
    else if (tick && count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/junction_sequencer.sv
// Three-aspect junction controller with latched minor-road and pedestrian requests.
// Pedestrian path (PED_WALK, ped_pend, round-robin) is built only with JUNCTION_PED_EN.
module junction_sequencer
  import junction_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_MAJ_MIN = DEF_T_MAJ_MIN,
  parameter int T_AMBER   = DEF_T_AMBER,
  parameter int T_ALLRED  = DEF_T_ALLRED,
  parameter int T_MIN_GRN = DEF_T_MIN_GRN,
  parameter int T_WALK    = DEF_T_WALK
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       car,
  input  logic       ped_req,
  output logic       major_red,
  output logic       major_amber,
  output logic       major_green,
  output logic       minor_red,
  output logic       minor_amber,
  output logic       minor_green,
  output logic       walk,
  output logic [2:0] phase
);

  phase_t           state, state_nxt;
  logic             expired, load;
  logic [CNT_W-1:0] load_val;
  logic             car_pend;
  logic             ped_want;

`ifdef JUNCTION_PED_EN
  logic ped_pend;
  req_t last;
  assign ped_want = ped_pend;
`else
  logic ped_unused;
  assign ped_unused = ped_req;
  assign ped_want   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (expired) begin
      case (state)
        MAJ_GRN:  if (car_pend || ped_want) state_nxt = MAJ_AMB;
        MAJ_AMB:  state_nxt = RED_A;
`ifdef JUNCTION_PED_EN
        // Both pending: serve whichever was not served last time.
        RED_A: begin
          if (car_pend && ped_pend) state_nxt = (last == PED) ? MIN_GRN : PED_WALK;
          else if (car_pend)        state_nxt = MIN_GRN;
          else if (ped_pend)        state_nxt = PED_WALK;
          else                      state_nxt = RED_B;
        end
`else
        RED_A:    state_nxt = MIN_GRN;
`endif
        MIN_GRN:  state_nxt = MIN_AMB;
        MIN_AMB:  state_nxt = RED_B;
        PED_WALK: state_nxt = RED_B;
        RED_B:    state_nxt = MAJ_GRN;
        default:  state_nxt = MAJ_GRN;
      endcase
    end
  end

  assign load = (state_nxt != state);

  always_comb begin
    case (state_nxt)
      MAJ_GRN:          load_val = CNT_W'(T_MAJ_MIN);
      MAJ_AMB, MIN_AMB: load_val = CNT_W'(T_AMBER);
      MIN_GRN:          load_val = CNT_W'(T_MIN_GRN);
      PED_WALK:         load_val = CNT_W'(T_WALK);
      default:          load_val = CNT_W'(T_ALLRED);
    endcase
  end

  interval_timer #(.CNT_W(CNT_W), .RST_VAL(T_MAJ_MIN)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .expired  (expired)
  );

  // Entering the serving state clears its request; requests seen while being served are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= MAJ_GRN;
      car_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load && state_nxt == MIN_GRN) car_pend <= 1'b0;
      else if (car && state != MIN_GRN) car_pend <= 1'b1;
    end
  end

`ifdef JUNCTION_PED_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ped_pend <= 1'b0;
      last     <= PED;
    end else begin
      if (load && state_nxt == PED_WALK)    ped_pend <= 1'b0;
      else if (ped_req && state != PED_WALK) ped_pend <= 1'b1;
      if (load && state_nxt == MIN_GRN)  last <= CAR;
      if (load && state_nxt == PED_WALK) last <= PED;
    end
  end
`endif

  always_comb begin
    major_red   = 1'b1;
    major_amber = 1'b0;
    major_green = 1'b0;
    minor_red   = 1'b1;
    minor_amber = 1'b0;
    minor_green = 1'b0;
    walk        = 1'b0;
    case (state)
      MAJ_GRN: begin major_red = 1'b0; major_green = 1'b1; end
      MAJ_AMB: begin major_red = 1'b0; major_amber = 1'b1; end
      MIN_GRN: begin minor_red = 1'b0; minor_green = 1'b1; end
      MIN_AMB: begin minor_red = 1'b0; minor_amber = 1'b1; end
`ifdef JUNCTION_PED_EN
      PED_WALK: walk = 1'b1;
`endif
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_junction_sequencer.sv
// Randomized and directed bench for junction_sequencer against a phase/duration table model.
module tb_junction_sequencer;
  import junction_pkg::*;

  logic clock = 1'b0;
  logic reset, tick, car, ped_req;
  logic major_red, major_amber, major_green, minor_red, minor_amber, minor_green, walk;
  logic [2:0] phase;

  junction_sequencer dut (
    .clock(clock), .reset(reset), .tick(tick), .car(car), .ped_req(ped_req),
    .major_red(major_red), .major_amber(major_amber), .major_green(major_green),
    .minor_red(minor_red), .minor_amber(minor_amber), .minor_green(minor_green),
    .walk(walk), .phase(phase)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a phase, ticks left in it, and the two request flags.
  phase_t m_ph = MAJ_GRN;
  int     m_left = 8;
  bit     m_car = 0, m_ped = 0, m_last_ped = 1;

  function automatic int dur(phase_t p);
    case (p)
      MAJ_GRN:          return 8;
      MAJ_AMB, MIN_AMB: return 3;
      MIN_GRN:          return 5;
      PED_WALK:         return 6;
      default:          return 1;
    endcase
  endfunction

  // {major r,a,g, minor r,a,g, walk}
  function automatic logic [6:0] lamps(phase_t p);
    case (p)
      MAJ_GRN:  return 7'b001_100_0;
      MAJ_AMB:  return 7'b010_100_0;
      MIN_GRN:  return 7'b100_001_0;
      MIN_AMB:  return 7'b100_010_0;
      PED_WALK: return 7'b100_100_1;
      default:  return 7'b100_100_0;
    endcase
  endfunction

  function automatic bit ped_en();
`ifdef JUNCTION_PED_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input bit t, input bit c, input bit p, input bit r);
    phase_t nxt;
    if (r) begin
      m_ph = MAJ_GRN; m_left = 8; m_car = 0; m_ped = 0; m_last_ped = 1;
      return;
    end
    nxt = m_ph;
    if (m_left == 0) begin
      case (m_ph)
        MAJ_GRN:  if (m_car || m_ped) nxt = MAJ_AMB;
        MAJ_AMB:  nxt = RED_A;
        RED_A: begin
          if (m_car && m_ped) nxt = m_last_ped ? MIN_GRN : PED_WALK;
          else if (m_ped)     nxt = PED_WALK;
          else if (m_car || !ped_en()) nxt = MIN_GRN;
          else                nxt = RED_B;
        end
        MIN_GRN:  nxt = MIN_AMB;
        MIN_AMB:  nxt = RED_B;
        default:  nxt = MAJ_GRN;
      endcase
    end
    if (c && m_ph != MIN_GRN)  m_car = 1;
    if (p && m_ph != PED_WALK && ped_en()) m_ped = 1;
    if (nxt != m_ph) begin
      if (nxt == MIN_GRN)  begin m_car = 0; m_last_ped = 0; end
      if (nxt == PED_WALK) begin m_ped = 0; m_last_ped = 1; end
      m_left = dur(nxt);
    end else if (t && m_left > 0) begin
      m_left--;
    end
    m_ph = nxt;
  endtask

  task automatic cyc(input bit t, input bit c, input bit p, input bit r);
    logic [6:0] obs;
    tick = t; car = c; ped_req = p; reset = r;
    @(posedge clock);
    model_edge(t, c, p, r);
    @(negedge clock);
    obs = {major_red, major_amber, major_green, minor_red, minor_amber, minor_green, walk};
    chk("phase", 32'(phase), 32'(m_ph));
    chk("lamps", 32'(obs), 32'(lamps(m_ph)));
    chk("one_major", 32'($countones(obs[6:4])), 1);
    chk("one_minor", 32'($countones(obs[3:1])), 1);
    chk("no_conflict", 32'((obs[5] | obs[4]) & (obs[2] | obs[1])), 0);
  endtask

  task automatic wait_phase(input phase_t target, input bit c, input bit p);
    int n = 0;
    while (phase_t'(phase) != target && n < 200) begin
      cyc(1, c, p, 0);
      n++;
    end
    chk("wait_phase_timeout", 32'(phase), 32'(target));
  endtask

  // Cycles spent in the current phase with tick held high.
  task automatic measure(input bit c, input bit p, output int n);
    phase_t p0 = phase_t'(phase);
    n = 0;
    while (phase_t'(phase) == p0 && n < 200) begin
      cyc(1, c, p, 0);
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1; tick = 0; car = 0; ped_req = 0;

    // Idle after reset: major green holds indefinitely.
    cyc(0, 0, 0, 1);
    chk("reset_phase", 32'(phase), 32'(MAJ_GRN));
    chk("reset_major_green", 32'(major_green), 1);
    chk("reset_minor_red", 32'(minor_red), 1);
    chk("reset_walk", 32'(walk), 0);
    for (int i = 0; i < 50; i++) cyc(1, 0, 0, 0);
    chk("idle_phase", 32'(phase), 32'(MAJ_GRN));

    // Single car: full minor-road cycle, each phase lasts T+1 cycles at tick-every-cycle.
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    wait_phase(MAJ_AMB, 0, 0);
    measure(0, 0, n); chk("amber_cycles", 32'(n), 4);
    measure(0, 0, n); chk("red_a_cycles", 32'(n), 2);
    chk("minor_green_now", 32'(minor_green), 1);
    measure(0, 0, n); chk("min_grn_cycles", 32'(n), 6);
    measure(0, 0, n); chk("min_amb_cycles", 32'(n), 4);
    measure(0, 0, n); chk("red_b_cycles", 32'(n), 2);
    chk("back_major", 32'(phase), 32'(MAJ_GRN));
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0);
    chk("car_cleared_hold", 32'(phase), 32'(MAJ_GRN));

`ifdef JUNCTION_PED_EN
    // Car and ped together: car first (last=PED), then walk after a minimum green.
    cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 0);
    wait_phase(RED_A, 0, 0);
    cyc(1, 0, 0, 0);
    chk("first_served", 32'(phase), 32'(MIN_GRN));
    wait_phase(MAJ_GRN, 0, 0);
    measure(0, 0, n); chk("maj_min_cycles", 32'(n), 9);
    wait_phase(PED_WALK, 0, 0);
    chk("walk_on", 32'(walk), 1);
    measure(0, 0, n); chk("walk_cycles", 32'(n), 7);

    // Button held through the walk: no repeat once released at the exit.
    cyc(0, 0, 0, 1);
    wait_phase(PED_WALK, 0, 1);
    wait_phase(RED_B, 0, 1);
    for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0);
    chk("no_repeat_walk", 32'(phase), 32'(MAJ_GRN));
`else
    // Pedestrian path absent: button pulses never move the lights.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 60; i++) cyc(1, 0, (i % 7) == 0, 0);
    chk("ped_ignored_phase", 32'(phase), 32'(MAJ_GRN));
    chk("ped_ignored_walk", 32'(walk), 0);
`endif

    // Reset mid-amber with a coincident tick, then the 8-tick minimum restarts.
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    wait_phase(MIN_AMB, 0, 0);
    cyc(1, 0, 0, 1);
    chk("reset_mid_phase", 32'(phase), 32'(MAJ_GRN));
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
    chk("reset_cleared_pend", 32'(phase), 32'(MAJ_GRN));
    cyc(0, 0, 0, 1);
    measure(1, 0, n); chk("restart_green_cycles", 32'(n), 9);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++)
      cyc(($urandom % 3) == 0, ($urandom % 40) == 0, ($urandom % 40) == 0, ($urandom % 600) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
